// File: rtl/mux2x1_arb.sv
// mux2x1_arb: round-robin arbiter between two valid/ready sources feeding a registered output beat.
// Define MUX2X1_ARB_PKT_LOCK_EN to hold the grant on one source until its last beat is accepted.
module mux2x1_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic             sel,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  output logic             y_last,
  input  logic             y_ready
);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t gnt;
  logic  prio;
  logic  slot_free;
  logic  acc;

`ifdef MUX2X1_ARB_PKT_LOCK_EN
  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;
  state_t state;
`endif

  // Grant depends only on registered state, prio and the valids, never on payload.
  always_comb begin
    sel = prio;
    if (a_valid && !b_valid)      sel = 1'b0;
    else if (b_valid && !a_valid) sel = 1'b1;
`ifdef MUX2X1_ARB_PKT_LOCK_EN
    if (state == LOCK_A)      sel = 1'b0;
    else if (state == LOCK_B) sel = 1'b1;
`endif
  end

  assign slot_free = !y_valid || y_ready;
  assign a_ready   = rst_n && slot_free && !sel;
  assign b_ready   = rst_n && slot_free &&  sel;
  assign acc       = sel ? (b_valid && b_ready) : (a_valid && a_ready);
  assign gnt       = sel ? beat_t'{last: b_last, data: b_data}
                         : beat_t'{last: a_last, data: a_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_data  <= '0;
      y_last  <= 1'b0;
      y_valid <= 1'b0;
      prio    <= 1'b0;
    end else begin
      if (acc) begin
        y_data  <= gnt.data;
        y_last  <= gnt.last;
        y_valid <= 1'b1;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
`ifdef MUX2X1_ARB_PKT_LOCK_EN
      if (acc && gnt.last) prio <= ~sel;
`else
      if (acc) prio <= ~sel;
`endif
    end
  end

`ifdef MUX2X1_ARB_PKT_LOCK_EN
  // Lock opens on a non-last accepted beat from IDLE and closes on that source's last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (acc && !gnt.last) state <= sel ? LOCK_B : LOCK_A;
        LOCK_A,
        LOCK_B:  if (acc && gnt.last)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mux2x1_arb.sv
// Directed self-checking bench for mux2x1_arb; outputs sampled on the falling edge.
module tb_mux2x1_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_data, b_data, y_data;
  logic       a_valid, a_last, a_ready;
  logic       b_valid, b_last, b_ready;
  logic       sel, y_valid, y_last, y_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mux2x1_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .sel(sel), .y_data(y_data), .y_valid(y_valid), .y_last(y_last), .y_ready(y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00; a_last = 1'b1; b_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b0;
    a_data = 8'hAA; b_data = 8'hBB; a_last = 1'b1; b_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({a_ready, b_ready} !== 2'b00) begin
        n_fail++; $display("FAIL reset_ready: got %b required 00", {a_ready, b_ready});
      end
      n_checks++;
      if (y_valid !== 1'b0 || y_data !== 8'h00 || y_last !== 1'b0) begin
        n_fail++; $display("FAIL reset_out: got v=%b d=%h l=%b required v=0 d=00 l=0", y_valid, y_data, y_last);
      end
      n_checks++;
      if (sel !== 1'b0) begin
        n_fail++; $display("FAIL reset_sel: got %b required 0", sel);
      end
    end
    rst_n = 1'b1; y_ready = 1'b1;
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_fail++; $display("FAIL release_ready: got %b required 10", {a_ready, b_ready});
    end
    @(negedge clk);
    n_checks++;
    if (y_valid !== 1'b1 || y_data !== 8'hAA) begin
      n_fail++; $display("FAIL release_first_beat: got v=%b d=%h required v=1 d=aa", y_valid, y_data);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0] a_in  [4] = '{8'h11, 8'h12, 8'h12, 8'h13};
    logic [7:0] b_in  [4] = '{8'h21, 8'h21, 8'h22, 8'h22};
    logic [7:0] exp_y [4] = '{8'h11, 8'h21, 8'h12, 8'h22};
    do_reset();
    y_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_last = 1'b1; b_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = a_in[i]; b_data = b_in[i];
      #1;
      n_checks++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got a=%b b=%b required a=%b b=%b", i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
      end
      @(negedge clk);
      n_checks++;
      if (y_valid !== 1'b1 || y_data !== exp_y[i] || y_last !== 1'b1) begin
        n_fail++; $display("FAIL rr_beat[%0d]: got v=%b d=%h l=%b required v=1 d=%h l=1", i, y_valid, y_data, y_last, exp_y[i]);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic       yr    [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic       av    [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] ad    [8] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03, 8'h04, 8'h04};
    logic       exp_r [8] = '{1, 1, 0, 0, 0, 1, 1, 0};
    logic       exp_v [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] exp_y [8] = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h04};
    do_reset();
    b_valid = 1'b0; a_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      y_ready = yr[i]; a_valid = av[i]; a_data = ad[i];
      #1;
      n_checks++;
      if (a_ready !== exp_r[i]) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b required %b", i, a_ready, exp_r[i]);
      end
      @(negedge clk);
      n_checks++;
      if (y_valid !== exp_v[i] || (exp_v[i] && y_data !== exp_y[i])) begin
        n_fail++; $display("FAIL bp_beat[%0d]: got v=%b d=%h required v=%b d=%h", i, y_valid, y_data, exp_v[i], exp_y[i]);
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic test_single_source();
    do_reset();
    y_ready = 1'b1; a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h5A; b_last = 1'b1;
    #1;
    n_checks++;
    if (sel !== 1'b1 || b_ready !== 1'b1 || a_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_grant: got sel=%b a=%b b=%b required sel=1 a=0 b=1", sel, a_ready, b_ready);
    end
    @(negedge clk);
    n_checks++;
    if (y_valid !== 1'b1 || y_data !== 8'h5A) begin
      n_fail++; $display("FAIL single_beat: got v=%b d=%h required v=1 d=5a", y_valid, y_data);
    end
    y_ready = 1'b0; a_valid = 1'b1; a_data = 8'h66; a_last = 1'b1;
    #1;
    n_checks++;
    if (sel !== 1'b0) begin
      n_fail++; $display("FAIL single_prio: got sel=%b required 0", sel);
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_packet_lock();
    logic [7:0] a_pkt [3] = '{8'hA0, 8'hA1, 8'hA2};
    logic [7:0] exp_y [4];
    int  ai;
    bit  b_done, acc_a, acc_b;
`ifdef MUX2X1_ARB_PKT_LOCK_EN
    exp_y = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
`else
    exp_y = '{8'hA0, 8'hB0, 8'hA1, 8'hA2};
`endif
    do_reset();
    y_ready = 1'b1; ai = 0; b_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_valid = (ai < 3); a_data = a_pkt[(ai < 3) ? ai : 2]; a_last = (ai == 2);
      b_valid = !b_done;  b_data = 8'hB0; b_last = 1'b1;
      #1;
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      n_checks++;
      if (a_ready && b_ready) begin
        n_fail++; $display("FAIL lock_both_ready[%0d]: got a=1 b=1 required at most one", i);
      end
      @(negedge clk);
      if (acc_a) ai++;
      if (acc_b) b_done = 1'b1;
      n_checks++;
      if (y_valid !== 1'b1 || y_data !== exp_y[i]) begin
        n_fail++; $display("FAIL lock_beat[%0d]: got v=%b d=%h required v=1 d=%h", i, y_valid, y_data, exp_y[i]);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] a_pkt [2] = '{8'hA0, 8'hA1};
    do_reset();
    y_ready = 1'b1; b_valid = 1'b0; a_valid = 1'b1; a_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_data = a_pkt[i];
      @(negedge clk);
      n_checks++;
      if (y_valid !== 1'b1 || y_data !== a_pkt[i] || y_last !== 1'b0) begin
        n_fail++; $display("FAIL midpkt_beat[%0d]: got v=%b d=%h l=%b required v=1 d=%h l=0", i, y_valid, y_data, y_last, a_pkt[i]);
      end
    end
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b1; b_data = 8'hB5; b_last = 1'b1;
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_fail++; $display("FAIL midpkt_rst_ready: got %b required 00", {a_ready, b_ready});
    end
    @(negedge clk);
    n_checks++;
    if (y_valid !== 1'b0) begin
      n_fail++; $display("FAIL midpkt_rst_valid: got %b required 0", y_valid);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (sel !== 1'b1 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL midpkt_grant: got sel=%b b=%b required sel=1 b=1", sel, b_ready);
    end
    @(negedge clk);
    n_checks++;
    if (y_valid !== 1'b1 || y_data !== 8'hB5 || y_last !== 1'b1) begin
      n_fail++; $display("FAIL midpkt_beat_b: got v=%b d=%h l=%b required v=1 d=b5 l=1", y_valid, y_data, y_last);
    end
    b_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00; a_last = 1'b0; b_last = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_source();
    test_packet_lock();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
